data_ram_resp: RTL

- Word-organised data memory that answers the load/store requests issued by the access (mem) stage, i.e. the responder side of the mem-stage data bus.
- Accepts one request at a time with byte-lane selects.
- Inserts a configurable number of wait states, then returns read data with a one-cycle acknowledge pulse.
- The mem stage holds its request and stalls the pipeline until the acknowledge arrives.

---
 rtl/data_ram_resp.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_ram_resp.sv
// data_ram_resp: word-organised data memory answering mem-stage load/store requests.
// One request is captured at a time, held for WAIT_CYCLES wait states, then completed
// with a one-cycle acknowledge. Stores commit byte lanes on the edge entering ACK; loads
// register the full word on that same edge.
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   mem_ce_i    request valid; dropping it during WAIT aborts the request
//   mem_we_i    1 = store, 0 = load
//   mem_sel_i   byte-lane enables for stores
//   mem_addr_i  byte address; bits [AW_WORDS+1:2] select the word
//   mem_data_i  store data
//   mem_data_o  load data, non-zero only during the ACK cycle of a load
//   mem_ack_o   one-cycle completion pulse
//   mem_busy_o  high while a captured request is outstanding (WAIT or ACK)
module data_ram_resp #(
  parameter int unsigned AW_WORDS    = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_busy_o
);

  localparam int unsigned Depth = 1 << AW_WORDS;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [AW_WORDS-1:0]   idx_q;
  logic [31:0]           wdata_q;
  logic                  ack_q;
  logic                  busy_q;
  logic [31:0]           rdata_q;

  logic [31:0]           mem [Depth];

  // Fields of the transaction that completes on this edge. With zero wait states the
  // request completes on its capture edge, so the live inputs are used directly.
  logic                  use_in;
  logic                  go_ack;
  logic                  commit;
  logic                  eff_we;
  logic [3:0]            eff_sel;
  logic [AW_WORDS-1:0]   eff_idx;
  logic [31:0]           eff_wdata;

  // Address bits outside the word index are intentionally ignored (wrap, no alignment check).
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:AW_WORDS+2], mem_addr_i[1:0]};

  always_comb begin
    use_in    = (state_q == StIdle);
    eff_we    = use_in ? mem_we_i : we_q;
    eff_sel   = use_in ? mem_sel_i : sel_q;
    eff_idx   = use_in ? mem_addr_i[AW_WORDS+1:2] : idx_q;
    eff_wdata = use_in ? mem_data_i : wdata_q;
    unique case (state_q)
      StIdle:  go_ack = mem_ce_i && (WAIT_CYCLES == 0);
      StWait:  go_ack = mem_ce_i && (cnt_q == 4'd0);
      default: go_ack = 1'b0;
    endcase
    // A reset edge never commits a store nor launches a read.
    commit = go_ack && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_q <= go_ack;
          if (mem_ce_i) begin
            we_q    <= mem_we_i;
            sel_q   <= mem_sel_i;
            idx_q   <= mem_addr_i[AW_WORDS+1:2];
            wdata_q <= mem_data_i;
            cnt_q   <= 4'(WAIT_CYCLES - 1);
            busy_q  <= 1'b1;
            state_q <= go_ack ? StAck : StWait;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        StWait: begin
          if (!mem_ce_i) begin
            // Requester withdrew: abort without write or ack.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
          end else if (go_ack) begin
            state_q <= StAck;
            ack_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        default: begin
          // ACK always returns to IDLE; a held ce is seen as a new request next cycle.
          state_q <= StIdle;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array write port with per-byte enables.
  always_ff @(posedge clk) begin
    if (commit && eff_we) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_sel[i]) begin
          mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read path; holds zero outside the ACK cycle of a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (commit && !eff_we) begin
      rdata_q <= mem[eff_idx];
    end else begin
      rdata_q <= 32'd0;
    end
  end

  assign mem_data_o = rdata_q;
  assign mem_ack_o  = ack_q;
  assign mem_busy_o = busy_q;

endmodule
